// File: rtl/ha_cfg_pkg.sv
// Shared definitions for the HA_CReg configuration loader, the host-side
// frame builder and the bench: FSM states, default magic and field layout.
package ha_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        STROBE,
        DONE
    } cfgState_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hC5;

    // Field layout, offsets counted down from the word MSB.
    localparam int unsigned FIELD_W       = 8;
    localparam int unsigned MAGIC_MSB_OFS = 0;  // header: magic
    localparam int unsigned COUNT_MSB_OFS = 8;  // header: payload count N
    localparam int unsigned TGT_MSB_OFS   = 0;  // payload: target index

endpackage

// File: rtl/ha_cfg_loader_if.sv
// Framed word stream from the host config port into the loader.
interface ha_cfg_loader_if #(
    parameter int unsigned DW = 32
);
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ha_cfg_loader.sv
// Configuration writer for HA_CReg registers: parses header + N payload
// words and emits a one-cycle EN strobe with InstIn per in-range payload.
module ha_cfg_loader
    import ha_cfg_pkg::*;
#(
    parameter int unsigned NUM_TGT = 4,
    parameter int unsigned INST_BW = 3,
    parameter int unsigned DW      = 32,
    parameter logic [7:0]  MAGIC   = MAGIC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    ha_cfg_loader_if.slave     s,
    output logic [NUM_TGT-1:0] creg_en,
    output logic [INST_BW-1:0] creg_inst,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic               cfg_err
);

    cfgState_t state, nextState;
    logic [7:0] cnt;

    logic               accept;
    logic [7:0]         wordMagic;
    logic [7:0]         wordCount;
    logic [7:0]         wordTgt;
    logic [INST_BW-1:0] wordInst;
    logic               magicOk;
    logic               tgtInRange;
    logic               unusedData;

    assign accept     = s.s_valid && s.s_ready;
    assign wordMagic  = s.s_data[DW-1-MAGIC_MSB_OFS -: FIELD_W];
    assign wordCount  = s.s_data[DW-1-COUNT_MSB_OFS -: FIELD_W];
    assign wordTgt    = s.s_data[DW-1-TGT_MSB_OFS -: FIELD_W];
    assign wordInst   = s.s_data[INST_BW-1:0];
    assign magicOk    = (wordMagic == MAGIC);
    assign tgtInRange = (32'(wordTgt) < NUM_TGT);
    // Middle bits of every word are don't-care by frame definition.
    assign unusedData = ^s.s_data;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        nextState = state;
        s.s_ready = 1'b0;
        cfg_busy  = 1'b0;
        cfg_done  = 1'b0;
        case (state)
            IDLE: nextState = HDR;
            HDR: begin
                s.s_ready = 1'b1;
                if (accept && magicOk)
                    nextState = (wordCount == 8'd0) ? DONE : LOAD;
            end
            LOAD: begin
                s.s_ready = 1'b1;
                cfg_busy  = 1'b1;
                if (accept) begin
                    if (tgtInRange)          nextState = STROBE;
                    else if (cnt == 8'd1)    nextState = DONE;
                end
            end
            STROBE: begin
                cfg_busy  = 1'b1;
                nextState = (cnt == 8'd1) ? DONE : LOAD;
            end
            DONE: begin
                cfg_busy  = 1'b1;
                cfg_done  = 1'b1;
                nextState = HDR;
            end
            default: nextState = IDLE;
        endcase
    end

    // Payload count, sticky error and registered strobe/InstIn. The strobe
    // is launched at the accept edge so it coincides with the STROBE state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            cfg_err   <= 1'b0;
            creg_en   <= '0;
            creg_inst <= '0;
        end else begin
            creg_en <= '0;
            case (state)
                HDR: begin
                    if (accept) begin
                        if (magicOk) begin
                            cnt     <= wordCount;
                            cfg_err <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (tgtInRange) begin
                            creg_en   <= NUM_TGT'(1) << wordTgt;
                            creg_inst <= wordInst;
                        end else begin
                            cfg_err <= 1'b1;
                            cnt     <= cnt - 8'd1;
                        end
                    end
                end
                STROBE: cnt <= cnt - 8'd1;
                default: ;
            endcase
        end
    end

endmodule
